chorus_mv: RTL

//  Multi-voice chorus effect with a triangle-LFO-swept delay per voice and selectable mode.

---
 rtl/chorus_mv_if.sv | 29 ++
 rtl/chorus_mv.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/chorus_mv_if.sv
// Sequencer and smart_ram signal bundle for the multi-voice chorus.
// The master drives requests and read data; the slave is the effect itself.
// Only the clock and reset stay outside this interface.
interface chorus_mv_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13
);
    logic                  i_cs;
    logic                  i_my_turn;
    logic [1:0]            i_mode;
    logic [DATA_WIDTH-1:0] i_data_in;
    logic [DATA_WIDTH-1:0] o_data_out;
    logic                  o_done;
    logic [1:0]            o_available_options;
    logic [DATA_WIDTH-1:0] i_sram_data_in;
    logic                  i_sram_read_finish;
    logic                  o_sram_rd;
    logic [ADDR_WIDTH-1:0] o_sram_offset;

    modport master (
        output i_cs, i_my_turn, i_mode, i_data_in, i_sram_data_in, i_sram_read_finish,
        input  o_data_out, o_done, o_available_options, o_sram_rd, o_sram_offset
    );

    modport slave (
        input  i_cs, i_my_turn, i_mode, i_data_in, i_sram_data_in, i_sram_read_finish,
        output o_data_out, o_done, o_available_options, o_sram_rd, o_sram_offset
    );
endinterface

// File: rtl/chorus_mv.sv
// Multi-voice chorus / vibrato / bypass with a triangle LFO sweeping each voice's delay.
// Latency: bypass done one edge after the request; chorus/vibrato done one edge after the last read returns.
// Backpressure: one smart_ram read outstanding at a time; waits indefinitely for read data in WAIT.
module chorus_mv #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 13,
    parameter int SAMPLERATE   = 48000,
    parameter int NUM_VOICES   = 3,
    parameter int MIN_DELAY_MS = 10,
    parameter int DEPTH        = 16,
    parameter int STEP_SAMPLES = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    chorus_mv_if.slave  bus
);
    localparam int SHIFT = $clog2(NUM_VOICES + 1);
    localparam int IW    = $clog2(DEPTH);
    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SW    = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam logic [1:0] MODE_BYPASS  = 2'b01;
    localparam logic [1:0] MODE_VIBRATO = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [1:0]                   r_mode;
    logic [VW-1:0]                r_voice;
    logic signed [DATA_WIDTH:0]   r_acc;
    logic [DATA_WIDTH-1:0]        r_data_out;
    logic                         r_sram_rd;
    logic [ADDR_WIDTH-1:0]        r_sram_offset;
    logic [SW-1:0]                r_step;
    logic [IW-1:0]                r_idx [NUM_VOICES];
    logic [NUM_VOICES-1:0]        r_dir;            // 1 = sweeping down

    logic                         w_accept;
    logic                         w_wait_fin;
    logic                         w_req_bypass;
    logic                         w_req_vib;
    logic                         w_vib;
    logic                         w_last_voice;
    logic [VW-1:0]                w_voice_inc;
    logic signed [DATA_WIDTH:0]   w_din_ext;
    logic signed [DATA_WIDTH:0]   w_din_sc;
    logic signed [DATA_WIDTH:0]   w_rd_ext;
    logic signed [DATA_WIDTH:0]   w_rd_sc;
    logic signed [DATA_WIDTH:0]   w_sum;
    logic [ADDR_WIDTH-1:0]        w_off_tab [DEPTH];

    // Offset per sweep position; computed in whole ms-samples then doubled so it is always even.
    for (genvar g = 0; g < DEPTH; g++) begin : g_off
        assign w_off_tab[g] = ADDR_WIDTH'(2 * (((MIN_DELAY_MS + g) * SAMPLERATE) / 1000));
    end

    assign w_req_bypass = (bus.i_mode == MODE_BYPASS);
    assign w_req_vib    = (bus.i_mode == MODE_VIBRATO);
    assign w_vib        = (r_mode == MODE_VIBRATO);
    assign w_last_voice = (r_voice == VW'(NUM_VOICES - 1));
    assign w_voice_inc  = r_voice + 1'b1;
    assign w_wait_fin   = (r_state == S_WAIT) && bus.i_sram_read_finish;

    // Each of the NUM_VOICES+1 terms is pre-scaled so their sum cannot leave DATA_WIDTH.
    assign w_din_ext = $signed({bus.i_data_in[DATA_WIDTH-1], bus.i_data_in});
    assign w_din_sc  = w_din_ext >>> SHIFT;
    assign w_rd_ext  = $signed({bus.i_sram_data_in[DATA_WIDTH-1], bus.i_sram_data_in});
    assign w_rd_sc   = w_rd_ext >>> SHIFT;
    assign w_sum     = r_acc + w_rd_sc;

    assign bus.o_data_out          = r_data_out;
    assign bus.o_done              = (r_state == S_DONE);
    assign bus.o_available_options = 2'b11;
    assign bus.o_sram_rd           = r_sram_rd;
    assign bus.o_sram_offset       = r_sram_offset;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_cs && bus.i_my_turn) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_bypass ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_sram_read_finish && (w_vib || w_last_voice)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sample datapath, read sequencing and LFO sweep.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode        <= '0;
            r_voice       <= '0;
            r_acc         <= '0;
            r_data_out    <= '0;
            r_sram_rd     <= 1'b0;
            r_sram_offset <= '0;
            r_step        <= '0;
            r_dir         <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_idx[v] <= IW'((v * DEPTH) / NUM_VOICES);
            end
        end else begin
            r_sram_rd <= 1'b0;

            if (w_accept) begin
                r_mode  <= bus.i_mode;
                r_voice <= '0;
                if (w_req_bypass) begin
                    r_data_out <= bus.i_data_in;
                end else begin
                    r_sram_rd     <= 1'b1;
                    r_sram_offset <= w_off_tab[r_idx[0]];
                    if (!w_req_vib) r_acc <= w_din_sc;
                end
            end

            if (w_wait_fin) begin
                if (w_vib) begin
                    r_data_out <= bus.i_sram_data_in;
                end else if (w_last_voice) begin
                    r_data_out <= w_sum[DATA_WIDTH-1:0];
                end else begin
                    r_acc         <= w_sum;
                    r_voice       <= w_voice_inc;
                    r_sram_rd     <= 1'b1;
                    r_sram_offset <= w_off_tab[r_idx[w_voice_inc]];
                end
            end

            // Every completed sample, bypass included, counts toward the next sweep step.
            if (r_state == S_DONE) begin
                if (r_step == SW'(STEP_SAMPLES - 1)) begin
                    r_step <= '0;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (r_dir[v]) begin
                            if (r_idx[v] == '0) begin
                                r_dir[v] <= 1'b0;
                                r_idx[v] <= IW'(1);
                            end else begin
                                r_idx[v] <= r_idx[v] - 1'b1;
                            end
                        end else begin
                            if (r_idx[v] == IW'(DEPTH - 1)) begin
                                r_dir[v] <= 1'b1;
                                r_idx[v] <= IW'(DEPTH - 2);
                            end else begin
                                r_idx[v] <= r_idx[v] + 1'b1;
                            end
                        end
                    end
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end
        end
    end
endmodule
